// File: rtl/pe_result_buffer_if.sv
// ---------------------------------------------------------------------------
// pe_result_buffer_if
// Purpose : bundles the ALU-side input stream and the routing-side output
//           stream of the PE result buffer into one interface.
// Signals : in_data/in_valid/in_ready   - ALU result stream (into buffer)
//           out_data/out_valid/out_ready - buffered result stream (to routing)
// Modports: master - the environment side (drives in_*, consumes out_*)
//           slave  - the buffer side (accepts in_*, produces out_*)
// ---------------------------------------------------------------------------
interface pe_result_buffer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pe_result_buffer.sv
// ---------------------------------------------------------------------------
// pe_result_buffer
// Purpose : two-entry in-order result FIFO behind a PE ALU, with an optional
//           accumulate mode that sums N = ACC_LEN+1 accepted beats (mod
//           2^WIDTH) and pushes only the completed sum.
// Ports   : clk     - user clock, all state changes on the rising edge
//           rst     - synchronous active-high reset
//           ACC_EN  - 0 = pass each beat through, 1 = accumulate
//           ACC_LEN - beats per accumulated output minus one
//           bus     - slave side of pe_result_buffer_if (in/out streams)
// ---------------------------------------------------------------------------
module pe_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ACC_EN,
    input  logic [3:0]          ACC_LEN,
    pe_result_buffer_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } accState_t;

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             head_q;
    logic             tail_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [3:0]       beat_q;
    logic [3:0]       beat_d;
    accState_t        state_q;
    accState_t        state_d;

    logic             inReady;
    logic             outValid;
    logic             accept;
    logic             pop;
    logic             push;
    logic             lastBeat;
    logic [WIDTH-1:0] accSum;
    logic [WIDTH-1:0] pushData;

    // Handshake qualifiers. in_ready looks only at registered occupancy (and
    // reset), so a full buffer stalls the ALU even if routing is draining.
    assign inReady  = (count_q < FULL_COUNT) && !rst;
    assign outValid = (count_q != 2'd0) && !rst;
    assign accept   = bus.in_valid && inReady;
    assign pop      = outValid && bus.out_ready;

    // A group completes when the beat counter reaches N-1; using >= lets a
    // shortened ACC_LEN mid-group close the sum on the very next beat.
    assign lastBeat = (beat_q >= ACC_LEN);
    assign accSum   = (beat_q == 4'd0) ? bus.in_data : (acc_q + bus.in_data);
    assign pushData = ACC_EN ? accSum : bus.in_data;
    assign push     = accept && (!ACC_EN || lastBeat);

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_data  = rst ? '0 : mem_q[head_q];

    // Occupancy: a push and pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Accumulator FSM next state. Leaving accumulate mode throws away any
    // partial sum by returning the beat counter to zero.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        if (!ACC_EN) begin
            state_d = IDLE;
            beat_d  = 4'd0;
        end else if (accept) begin
            acc_d = accSum;
            if (lastBeat) begin
                beat_d  = 4'd0;
                state_d = IDLE;
            end else begin
                beat_d  = beat_q + 4'd1;
                state_d = RUN;
            end
        end
    end

    // State registers: FIFO storage/pointers and accumulator FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            acc_q   <= '0;
            beat_q  <= 4'd0;
            state_q <= IDLE;
        end else begin
            if (push) begin
                mem_q[tail_q] <= pushData;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            state_q <= state_d;
        end
    end

endmodule

// File: doc/pe_result_buffer.md
PE_RESULT_BUFFER -- requirements
Module: pe_result_buffer

Interface
REQ-001 Parameter WIDTH, default 32: data width, equal to the ALU data_out width.
REQ-002 Parameter DEPTH, default 2: FIFO entries, fixed at 2 for this release.
REQ-003 clk  input  1  single user clock (FABulous USER_CLK); all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  WIDTH  ALU result (ALU data_out).
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  buffer accepts in_data this cycle.
REQ-008 out_data  output  WIDTH  head-of-FIFO result toward routing.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 ACC_EN  input  1  config bit; 0 = pass mode, 1 = accumulate mode.
REQ-012 ACC_LEN  input  4  config bits; beats per accumulated output, N = ACC_LEN+1 (1..16).

Function
REQ-013 Input handshake: beat accepted when in_valid && in_ready. Output handshake: beat consumed when out_valid && out_ready.
REQ-014 FIFO: 2 entries, occupancy count 0..2, strict in-order.
- out_valid = (count>0).
- out_data = head entry.
REQ-015 in_ready = (count<2) && !rst, registered-path only; no combinational dependence on out_ready.
- Full FIFO: in_ready=0 even when out_ready=1.
REQ-016 Simultaneous push and pop with count=1: count stays 1, popped entry leaves, pushed entry becomes head next cycle.
REQ-017 Pass mode (ACC_EN=0): each accepted beat is pushed unchanged.
- Latency: out_valid at the next rising edge after acceptance when FIFO was empty.
REQ-018 Accumulate mode (ACC_EN=1): FSM with states IDLE (beat=0) and RUN (0<beat<N).
- Registers: acc[WIDTH-1:0], beat[3:0].
REQ-019 On each accepted beat, acc_next = (beat==0 ? in_data : acc+in_data), truncated mod 2^WIDTH, no saturation, no carry output.
REQ-020 If beat==N-1 on acceptance:
- acc_next is pushed to the FIFO in the same cycle.
- beat <= 0; FSM returns to IDLE.
REQ-021 Otherwise beat <= beat+1, FSM goes to or stays in RUN, and nothing is pushed.
REQ-022 N=1 in accumulate mode behaves identically to pass mode.
REQ-023 Cycles without acceptance leave acc, beat and FSM state unchanged.
REQ-024 ACC_EN deasserted while in RUN:
- Partial sum discarded; beat <= 0; FSM <= IDLE on the next edge.
- FIFO contents unaffected.
REQ-025 ACC_LEN is sampled on every acceptance. Changing it in RUN takes effect immediately. If the new N-1 < beat, the next accepted beat completes the sum.
REQ-026 ACC_EN=1 and ACC_EN=0 use the same in_ready rule (REQ-015).

Reset
REQ-027 While rst=1 at a rising edge, all of the following are cleared:
- count=0, head/tail pointers=0, FIFO storage=0.
- acc=0, beat=0, FSM=IDLE.
REQ-028 Output values:
- During reset cycles: out_valid=0, out_data=0, in_ready=0.
- First cycle after deassertion: in_ready=1.
REQ-029 Reset mid-accumulation or with a non-empty FIFO discards all data; no output beat is produced for discarded data.
REQ-030 Beats presented with rst=1 are not accepted.

Verification
REQ-031 Backpressure, pass mode: push 5,7,9 back-to-back with out_ready=0.
- 5 and 7 accepted; in_ready=0 while 9 is held; out_data=5.
- Then out_ready=1: outputs 5,7,9 in order, no loss or duplication.
REQ-032 Accumulate, ACC_LEN=2: accept 1,2,3 with out_ready=1.
- Exactly one output, 6, with out_valid one cycle after the 3rd acceptance.
- Next group 4,4,4 gives 12.
REQ-033 Wrap, ACC_LEN=1, WIDTH=32: accept 0xFFFFFFFF then 0x00000002 -> output 0x00000001.
REQ-034 Simultaneous push/pop at count=1, pass mode: stream 1..10 with in_valid=out_ready=1 continuously.
- Count holds 1; outputs 1..10 at one per cycle.
REQ-035 Reset mid-run, ACC_LEN=3: accept 10,20, then rst for 1 cycle, then accept 1,1,1,1.
- Single output 4; the first cycle after reset shows out_valid=0 and in_ready=1.
REQ-036 Mode drop, ACC_LEN=3: accept 5,5, set ACC_EN=0, then accept 9 -> output 9 only; the partial sum 10 never appears.
